// File: rtl/ltl_automata_engine.sv
// ltl_automata_engine: programmable homogeneous automaton with range matching, in-edge masks and report statistics
module ltl_automata_engine #(
    parameter int NUM_STATES = 11,
    parameter int SYM_W = 8,
    parameter int NUM_RANGES = 4,
    parameter int CNT_W = 16,
    localparam int RNG_W = 2 * SYM_W + 1,
    localparam int CFG_W = RNG_W > NUM_STATES ? RNG_W : NUM_STATES,
    localparam int ST_W = NUM_STATES > 1 ? $clog2(NUM_STATES) : 1,
    localparam int SUB_W = NUM_RANGES > 1 ? $clog2(NUM_RANGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  clear,
    input  logic [SYM_W-1:0]      symbols,
    input  logic                  cfg_we,
    input  logic [ST_W-1:0]       cfg_state,
    input  logic [1:0]            cfg_kind,
    input  logic [SUB_W-1:0]      cfg_sub,
    input  logic [CFG_W-1:0]      cfg_data,
    output logic [NUM_STATES-1:0] active,
    output logic [NUM_STATES-1:0] report_vec,
    output logic                  report_any,
    output logic                  report_sticky,
    output logic [CNT_W-1:0]      report_cnt,
    output logic [CNT_W-1:0]      sym_cnt,
    output logic [CNT_W-1:0]      first_pos,
    output logic                  first_valid
);
    logic [NUM_RANGES-1:0][RNG_W-1:0] rng_q [NUM_STATES];
    logic [NUM_STATES-1:0] in_mask_q [NUM_STATES];
    logic [NUM_STATES-1:0] rpt_q, start_all_q, start_sod_q;
    logic [NUM_STATES-1:0] match, nxt;
    logic sod, nxt_any, cfg_ok, sub_ok;

    assign cfg_ok = cfg_we && !run && !clear && ({1'b0, cfg_state} < (ST_W + 1)'(NUM_STATES));
    assign sub_ok = {1'b0, cfg_sub} < (SUB_W + 1)'(NUM_RANGES);

    // slot layout is {en, hi, lo}; lo > hi naturally never matches
    always_comb begin
        match = '0;
        nxt = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            for (int r = 0; r < NUM_RANGES; r++)
                match[i] = match[i] | (rng_q[i][r][RNG_W-1]
                    && symbols >= rng_q[i][r][SYM_W-1:0]
                    && symbols <= rng_q[i][r][2*SYM_W-1:SYM_W]);
            nxt[i] = match[i] & ((|(in_mask_q[i] & active)) | (start_sod_q[i] & sod) | start_all_q[i]);
        end
    end

    assign nxt_any = |(nxt & rpt_q);
    assign report_vec = active & rpt_q;
    assign report_any = |report_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                rng_q[i] <= '0;
                in_mask_q[i] <= '0;
            end
            rpt_q <= '0;
            start_all_q <= '0;
            start_sod_q <= '0;
        end else if (cfg_ok) begin
            if (cfg_kind == 2'd0 && sub_ok)
                rng_q[cfg_state][cfg_sub] <= cfg_data[RNG_W-1:0];
            if (cfg_kind == 2'd1)
                in_mask_q[cfg_state] <= cfg_data[NUM_STATES-1:0];
            if (cfg_kind == 2'd2) begin
                rpt_q[cfg_state] <= cfg_data[2];
                start_all_q[cfg_state] <= cfg_data[1];
                start_sod_q[cfg_state] <= cfg_data[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            active <= '0;
            sod <= 1'b1;
            report_sticky <= 1'b0;
            report_cnt <= '0;
            sym_cnt <= '0;
            first_pos <= '0;
            first_valid <= 1'b0;
        end else if (run) begin
            active <= nxt;
            sod <= 1'b0;
            sym_cnt <= sym_cnt + CNT_W'(!(&sym_cnt));
            if (nxt_any) begin
                report_sticky <= 1'b1;
                report_cnt <= report_cnt + CNT_W'(!(&report_cnt));
                if (!first_valid) begin
                    first_pos <= sym_cnt;
                    first_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ltl_automata_engine.sv
// tb_ltl_automata_engine: directed and randomized checks against a set-based behavioural model
module tb_ltl_automata_engine;
    localparam int NS = 11;
    localparam int MAXC = 65535;

    logic clk = 1'b0;
    logic reset = 1'b0, run = 1'b0, clear = 1'b0, cfg_we = 1'b0;
    logic [7:0] symbols = '0;
    logic [3:0] cfg_state = '0;
    logic [1:0] cfg_kind = '0, cfg_sub = '0;
    logic [16:0] cfg_data = '0;
    logic [NS-1:0] active, report_vec;
    logic report_any, report_sticky, first_valid;
    logic [15:0] report_cnt, sym_cnt, first_pos;

    int pass_cnt = 0, total_cnt = 0;

    bit [7:0] m_lo [NS][4];
    bit [7:0] m_hi [NS][4];
    bit m_en [NS][4];
    bit [NS-1:0] m_mask [NS];
    bit [NS-1:0] m_rpt, m_sall, m_ssod, m_active;
    bit m_sod, m_sticky, m_fv;
    int m_sym, m_rc, m_fp;

    ltl_automata_engine dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .symbols(symbols),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_kind(cfg_kind), .cfg_sub(cfg_sub),
        .cfg_data(cfg_data), .active(active), .report_vec(report_vec), .report_any(report_any),
        .report_sticky(report_sticky), .report_cnt(report_cnt), .sym_cnt(sym_cnt),
        .first_pos(first_pos), .first_valid(first_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_active = '0; m_sod = 1; m_sticky = 0; m_fv = 0; m_sym = 0; m_rc = 0; m_fp = 0;
    endtask

    // a state becomes active when the symbol lies in one of its enabled ranges and it is fed
    task automatic model_step(input int s);
        bit [NS-1:0] na;
        bit hit, fed;
        na = '0;
        for (int i = 0; i < NS; i++) begin
            hit = 0;
            fed = m_sall[i] || (m_ssod[i] && m_sod);
            for (int r = 0; r < 4; r++)
                if (m_en[i][r] && s >= int'(m_lo[i][r]) && s <= int'(m_hi[i][r])) hit = 1;
            for (int j = 0; j < NS; j++)
                if (m_mask[i][j] && m_active[j]) fed = 1;
            na[i] = hit && fed;
        end
        m_active = na;
        m_sod = 0;
        if ((na & m_rpt) != 0) begin
            m_sticky = 1;
            if (m_rc < MAXC) m_rc++;
            if (!m_fv) begin m_fp = m_sym; m_fv = 1; end
        end
        if (m_sym < MAXC) m_sym++;
    endtask

    task automatic do_reset();
        reset = 1; run = 0; clear = 0; cfg_we = 0;
        tick();
        reset = 0;
        for (int i = 0; i < NS; i++) begin
            m_mask[i] = '0;
            for (int r = 0; r < 4; r++) begin m_lo[i][r] = 0; m_hi[i][r] = 0; m_en[i][r] = 0; end
        end
        m_rpt = '0; m_sall = '0; m_ssod = '0;
        model_clear();
    endtask

    task automatic cfg_write(input int st, input int kind, input int sub, input bit [16:0] d);
        run = 0; clear = 0; cfg_we = 1;
        cfg_state = 4'(st); cfg_kind = 2'(kind); cfg_sub = 2'(sub); cfg_data = d;
        tick();
        cfg_we = 0;
        if (st < NS) begin
            if (kind == 0) begin m_en[st][sub] = d[16]; m_hi[st][sub] = d[15:8]; m_lo[st][sub] = d[7:0]; end
            if (kind == 1) m_mask[st] = d[NS-1:0];
            if (kind == 2) begin m_rpt[st] = d[2]; m_sall[st] = d[1]; m_ssod[st] = d[0]; end
        end
    endtask

    task automatic set_range(input int st, input int sub, input int lo, input int hi);
        cfg_write(st, 0, sub, {1'b1, 8'(hi), 8'(lo)});
    endtask

    task automatic feed(input int s);
        run = 1; symbols = 8'(s);
        tick();
        run = 0;
        model_step(s);
    endtask

    task automatic do_clear(input bit with_run);
        clear = 1; run = with_run; symbols = 8'($urandom);
        tick();
        clear = 0; run = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (active !== '0) $display("FAIL reset_active: got %b want 0", active); else pass_cnt++;
        total_cnt++; if ({report_cnt, sym_cnt, first_pos} !== '0) $display("FAIL reset_counters: got %h %h %h want 0", report_cnt, sym_cnt, first_pos); else pass_cnt++;
        total_cnt++; if ({report_sticky, first_valid, report_any} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {report_sticky, first_valid, report_any}); else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        set_range(0, 0, 0, 15);
        cfg_write(0, 2, 0, 17'b101);
        feed(5);
        total_cnt++; if (active !== 11'd1 || report_cnt !== 16'd1) $display("FAIL single_first: got active=%b rc=%0d want 1/1", active, report_cnt); else pass_cnt++;
        feed(5);
        total_cnt++; if (active !== 11'd0 || report_cnt !== 16'd1) $display("FAIL single_second: got active=%b rc=%0d want 0/1", active, report_cnt); else pass_cnt++;
    endtask

    task automatic test_chain();
        do_reset();
        set_range(0, 0, 0, 15);
        cfg_write(0, 2, 0, 17'b001);
        set_range(1, 0, 16, 31);
        cfg_write(1, 2, 0, 17'b100);
        cfg_write(1, 1, 0, 17'b01);
        feed(3);
        total_cnt++; if (report_any !== 1'b0 || active !== 11'b01) $display("FAIL chain_first: got any=%b active=%b want 0/01", report_any, active); else pass_cnt++;
        feed(20);
        total_cnt++; if (report_any !== 1'b1 || active !== 11'b10) $display("FAIL chain_second: got any=%b active=%b want 1/10", report_any, active); else pass_cnt++;
        total_cnt++; if (first_pos !== 16'd1 || first_valid !== 1'b1) $display("FAIL chain_first_pos: got %0d/%b want 1/1", first_pos, first_valid); else pass_cnt++;
    endtask

    task automatic test_start_all();
        do_reset();
        set_range(2, 3, 64, 79);
        cfg_write(2, 2, 0, 17'b110);
        feed(0); feed(70); feed(0); feed(70);
        total_cnt++; if (report_cnt !== 16'd2 || sym_cnt !== 16'd4 || first_pos !== 16'd1) $display("FAIL start_all: got rc=%0d sc=%0d fp=%0d want 2/4/1", report_cnt, sym_cnt, first_pos); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_range(0, 0, 0, 255);
        cfg_write(0, 1, 0, 17'b1);
        cfg_write(0, 2, 0, 17'b101);
        for (int n = 0; n < 65536 + 5; n++) feed(int'($urandom_range(0, 255)));
        total_cnt++; if (report_cnt !== 16'hFFFF || sym_cnt !== 16'hFFFF) $display("FAIL sat_counts: got rc=%h sc=%h want ffff/ffff", report_cnt, sym_cnt); else pass_cnt++;
        total_cnt++; if (first_pos !== 16'd0 || first_valid !== 1'b1 || active !== 11'd1) $display("FAIL sat_first: got fp=%0d fv=%b active=%b want 0/1/1", first_pos, first_valid, active); else pass_cnt++;
        total_cnt++; if (report_cnt !== 16'(m_rc) || sym_cnt !== 16'(m_sym)) $display("FAIL sat_model: got %h/%h want %h/%h", report_cnt, sym_cnt, 16'(m_rc), 16'(m_sym)); else pass_cnt++;
    endtask

    task automatic test_cfg_drop_and_clear();
        do_reset();
        set_range(0, 0, 0, 15);
        cfg_write(0, 2, 0, 17'b101);
        run = 1; symbols = 8'd5; cfg_we = 1; cfg_state = 4'd0; cfg_kind = 2'd2; cfg_data = '0;
        tick();
        run = 0; cfg_we = 0;
        model_step(5);
        total_cnt++; if (active !== 11'd1 || report_cnt !== 16'd1) $display("FAIL drop_first: got active=%b rc=%0d want 1/1", active, report_cnt); else pass_cnt++;
        feed(5);
        do_clear(1'b1);
        total_cnt++; if (active !== '0 || {report_cnt, sym_cnt} !== '0 || report_sticky !== 1'b0 || first_valid !== 1'b0) $display("FAIL clear_state: got active=%b rc=%0d sc=%0d st=%b fv=%b want all 0", active, report_cnt, sym_cnt, report_sticky, first_valid); else pass_cnt++;
        feed(7);
        total_cnt++; if (active !== 11'd1 || report_cnt !== 16'd1 || sym_cnt !== 16'd1 || first_pos !== 16'd0) $display("FAIL clear_sod: got active=%b rc=%0d sc=%0d fp=%0d want 1/1/1/0", active, report_cnt, sym_cnt, first_pos); else pass_cnt++;
    endtask

    task automatic test_gap();
        do_reset();
        set_range(0, 0, 0, 15);
        cfg_write(0, 1, 0, 17'b1);
        cfg_write(0, 2, 0, 17'b101);
        set_range(1, 1, 100, 200);
        cfg_write(1, 2, 0, 17'b101);
        feed(5); feed(5);
        for (int g = 0; g < 3; g++) begin
            run = 0; symbols = 8'(150 + g);
            tick();
            total_cnt++; if (active !== 11'b01 || sym_cnt !== 16'd2 || report_cnt !== 16'd2) $display("FAIL gap_hold%0d: got active=%b sc=%0d rc=%0d want 01/2/2", g, active, sym_cnt, report_cnt); else pass_cnt++;
        end
        feed(150);
        total_cnt++; if (active !== 11'b00 || sym_cnt !== 16'd3) $display("FAIL gap_no_sod: got active=%b sc=%0d want 00/3", active, sym_cnt); else pass_cnt++;
    endtask

    task automatic random_config();
        int lo, hi;
        for (int i = 0; i < NS; i++) begin
            for (int r = 0; r < 2; r++) begin
                lo = int'($urandom_range(0, 255));
                hi = lo + int'($urandom_range(0, 60));
                if (hi > 255) hi = 255;
                if ($urandom_range(0, 7) == 0 && lo > 0) hi = lo - 1;
                cfg_write(i, 0, int'($urandom_range(0, 3)), {1'($urandom_range(0, 3) != 0), 8'(hi), 8'(lo)});
            end
            cfg_write(i, 1, 0, 17'($urandom) & 17'h7FF);
            cfg_write(i, 2, 0, 17'($urandom_range(0, 7)));
        end
        cfg_write(int'($urandom_range(11, 15)), 2, 0, 17'b111);
        cfg_write(int'($urandom_range(0, 10)), 3, 0, 17'h1FFFF);
    endtask

    task automatic test_random();
        logic [72:0] got, exp;
        int act;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            random_config();
            for (int n = 0; n < 300; n++) begin
                act = int'($urandom_range(0, 99));
                if (act < 70) feed(int'($urandom_range(0, 255)));
                else if (act < 80) begin symbols = 8'($urandom); tick(); end
                else if (act < 85) do_clear(1'($urandom));
                else if (act < 92) cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 17'($urandom));
                else begin
                    run = 1; symbols = 8'($urandom); cfg_we = 1; cfg_state = 4'($urandom_range(0, 10));
                    cfg_kind = 2'($urandom); cfg_sub = 2'($urandom); cfg_data = 17'($urandom);
                    tick();
                    run = 0; cfg_we = 0;
                    model_step(int'(symbols));
                end
                got = {active, report_vec, report_any, report_sticky, report_cnt, sym_cnt, first_valid, first_pos};
                exp = {m_active, m_active & m_rpt, |(m_active & m_rpt), m_sticky, 16'(m_rc), 16'(m_sym), m_fv, 16'(m_fp)};
                total_cnt++; if (got !== exp) $display("FAIL random_r%0d_n%0d: got %h want %h", round, n, got, exp); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_start_all();
        test_cfg_drop_and_clear();
        test_gap();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
